// File: rtl/shift_serializer_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Types and helpers shared by the word serializer and the matching deserializer.
//   shift_state_e : frame FSM state (IDLE waiting for a frame, SHIFT emitting)
//   calc_cntw     : beat-counter width, clog2 with a floor of one bit
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic {IDLE, SHIFT} shift_state_e;

  // A one-word frame still needs a 1-bit counter so the compare logic has a width.
  function automatic int calc_cntw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// -----------------------------------------------------------------------------
// shift_serializer_if
// Groups the load port and the output stream of the serializer.
//   iLoadValid / oLoadReady / iLoadData : parallel frame load handshake
//   oValid / iReady / oData / oLast     : word-serial output stream
//   oBusy                               : a frame is in flight
// Modport slave is the serializer side, master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface shift_serializer_if #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8
);

  logic                        iLoadValid;
  logic                        oLoadReady;
  logic [BITWIDTH*DEPTH-1:0]   iLoadData;
  logic                        oValid;
  logic                        iReady;
  logic [BITWIDTH-1:0]         oData;
  logic                        oLast;
  logic                        oBusy;

  modport slave (
    input  iLoadValid, iLoadData, iReady,
    output oLoadReady, oValid, oData, oLast, oBusy
  );

  modport master (
    output iLoadValid, iLoadData, iReady,
    input  oLoadReady, oValid, oData, oLast, oBusy
  );

endinterface

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
// Accepts one DEPTH-word frame through a valid/ready load port and emits it one
// word per beat, word 0 first. A new frame can be loaded on the final beat so
// consecutive frames stream with no bubble.
// Ports:
//   iClk  : clock, rising edge
//   iRst  : synchronous active-high reset
//   iClr  : synchronous frame abort/flush
//   bus   : shift_serializer_if.slave (load port + output stream + oBusy)
// -----------------------------------------------------------------------------
module shift_serializer
  import shift_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iClr,
  shift_serializer_if.slave bus
);

  localparam int              CNTW     = calc_cntw(DEPTH);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DEPTH - 1);

  shift_state_e        r_state;
  shift_state_e        w_state_next;
  logic [CNTW-1:0]     r_cnt;
  logic [CNTW-1:0]     w_cnt_next;
  logic [BITWIDTH-1:0] w_bank [DEPTH];

  logic w_flush;
  logic w_in_shift;
  logic w_last;
  logic w_beat;
  logic w_load_ready;
  logic w_load;

  assign w_flush    = iRst | iClr;
  assign w_in_shift = (r_state == SHIFT);
  assign w_last     = w_in_shift && (r_cnt == LAST_CNT);
  // A beat presented during a flush is not delivered.
  assign w_beat     = w_in_shift & bus.iReady & ~w_flush;
  // Ready on the final beat lets the next frame enter with no bubble; it
  // deliberately depends on iReady but never on iLoadValid.
  assign w_load_ready = ~w_flush & (~w_in_shift | (w_last & bus.iReady));
  assign w_load       = bus.iLoadValid & w_load_ready;

  // Next-state / counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (iClr) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else if (w_load) begin
      // Covers both the IDLE load and the reload on the final beat.
      w_state_next = SHIFT;
      w_cnt_next   = '0;
    end else if (w_beat) begin
      if (w_last) begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + CNTW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Frame bank: each word shifts down toward word 0 on a beat, the top word
  // refills with zero so a drained bank reads back as all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bank
      logic [BITWIDTH-1:0] r_word;
      logic [BITWIDTH-1:0] w_shift_in;

      if (gi == DEPTH - 1) begin : g_top
        assign w_shift_in = '0;
      end else begin : g_mid
        assign w_shift_in = w_bank[gi+1];
      end

      always_ff @(posedge iClk) begin
        if (w_flush) begin
          r_word <= '0;
        end else if (w_load) begin
          r_word <= bus.iLoadData[gi*BITWIDTH +: BITWIDTH];
        end else if (w_beat) begin
          r_word <= w_shift_in;
        end
      end

      assign w_bank[gi] = r_word;
    end
  endgenerate

  // Outputs are forced quiet while reset is asserted, even in the first reset
  // cycle when the state register may still hold SHIFT.
  assign bus.oLoadReady = w_load_ready;
  assign bus.oValid     = w_in_shift & ~iRst;
  assign bus.oBusy      = w_in_shift & ~iRst;
  assign bus.oLast      = w_last & ~iRst;
  assign bus.oData      = (w_in_shift & ~iRst) ? w_bank[0] : '0;

endmodule
